// File: rtl/alu_pkg.sv
// Shared constants for the ripple-carry ALU: operation encodings and default width.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

endpackage

// File: rtl/alu_bit_slice.sv
// One bit of the ripple ALU: optional B inversion, full adder and AND/OR/ADD/LESS result mux.
// set/overflow are only meaningful on the MSB slice.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_binvert,
    input  logic       i_cin,
    input  logic       i_less,
    input  logic [1:0] i_op,
    output logic       o_result_c,
    output logic       o_cout_c,
    output logic       o_set_c,
    output logic       o_ovf_c
);

    logic w_bb;
    logic w_sum;

    assign w_bb     = i_binvert ? ~i_b : i_b;
    assign w_sum    = i_a ^ w_bb ^ i_cin;
    assign o_cout_c = (i_a & w_bb) | (i_a & i_cin) | (w_bb & i_cin);
    assign o_set_c  = w_sum;
    assign o_ovf_c  = (i_a == w_bb) && (w_sum != i_a);

    always_comb begin
        o_result_c = 1'b0;
        case (i_op)
            OP_AND:  o_result_c = i_a & w_bb;
            OP_OR:   o_result_c = i_a | w_bb;
            OP_ADD:  o_result_c = w_sum;
            default: o_result_c = i_less;
        endcase
    end

endmodule

// File: rtl/alu_32.sv
// Registered WIDTH-bit ripple ALU (AND/OR/ADD-SUB/SLT) with one cycle of latency.
// Define ALU_FLAGS_EN to add the registered Zero and Overflow outputs.
module alu_32
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Binvert,
    input  logic [1:0]       Operation,
    input  logic             Carryin,
`ifdef ALU_FLAGS_EN
    output logic             Zero,
    output logic             Overflow,
`endif
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut
);

    logic [WIDTH-1:0] w_result;
    logic             w_msb_set;
    logic             w_msb_ovf;
    logic             w_less;
    logic             w_cout;

    // SLT feeds the signed comparison from the MSB back into bit 0.
    assign w_less = w_msb_set ^ w_msb_ovf;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        logic w_cin;
        logic w_cout_bit;
        logic w_res_bit;
        logic w_less_in;

        if (i == 0) begin : g_lsb
            assign w_cin     = Carryin;
            assign w_less_in = w_less;
        end else begin : g_upper
            assign w_cin     = g_slice[i-1].w_cout_bit;
            assign w_less_in = 1'b0;
        end

        if (i == WIDTH - 1) begin : g_msb
            alu_bit_slice u_slice (
                .i_a        (a[i]),
                .i_b        (b[i]),
                .i_binvert  (Binvert),
                .i_cin      (w_cin),
                .i_less     (w_less_in),
                .i_op       (Operation),
                .o_result_c (w_res_bit),
                .o_cout_c   (w_cout_bit),
                .o_set_c    (w_msb_set),
                .o_ovf_c    (w_msb_ovf)
            );
        end else begin : g_mid
            logic w_set_unused;
            logic w_ovf_unused;
            alu_bit_slice u_slice (
                .i_a        (a[i]),
                .i_b        (b[i]),
                .i_binvert  (Binvert),
                .i_cin      (w_cin),
                .i_less     (w_less_in),
                .i_op       (Operation),
                .o_result_c (w_res_bit),
                .o_cout_c   (w_cout_bit),
                .o_set_c    (w_set_unused),
                .o_ovf_c    (w_ovf_unused)
            );
        end

        assign w_result[i] = w_res_bit;
    end

    assign w_cout = g_slice[WIDTH-1].w_cout_bit;

    logic [WIDTH-1:0] r_result;
    logic             r_carry;

`ifdef ALU_FLAGS_EN
    logic r_zero;
    logic r_ovf;

    // Overflow is reported only for the adder-based operations.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_zero <= 1'b1;
            r_ovf  <= 1'b0;
        end else begin
            r_zero <= (w_result == '0);
            r_ovf  <= Operation[1] & w_msb_ovf;
        end
    end

    assign Zero     = r_zero;
    assign Overflow = r_ovf;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result <= '0;
            r_carry  <= 1'b0;
        end else begin
            r_result <= w_result;
            r_carry  <= w_cout;
        end
    end

    assign Result   = r_result;
    assign CarryOut = r_carry;

endmodule

// File: tb/tb_alu_32.sv
// Directed self-checking bench for alu_32; define ALU_FLAGS_EN to also check Zero/Overflow.
module tb_alu_32;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        Binvert;
    logic [1:0]  Operation;
    logic        Carryin;
    logic [31:0] Result;
    logic        CarryOut;
`ifdef ALU_FLAGS_EN
    logic        Zero;
    logic        Overflow;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    alu_32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .Binvert   (Binvert),
        .Operation (Operation),
        .Carryin   (Carryin),
`ifdef ALU_FLAGS_EN
        .Zero      (Zero),
        .Overflow  (Overflow),
`endif
        .Result    (Result),
        .CarryOut  (CarryOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] va, input logic [31:0] vb,
                         input logic vbinv, input logic [1:0] vop, input logic vcin);
        a         = va;
        b         = vb;
        Binvert   = vbinv;
        Operation = vop;
        Carryin   = vcin;
    endtask

    // Apply one vector, step one edge, check the registered outputs.
    task automatic step(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic vbinv, input logic [1:0] vop, input logic vcin,
                        input logic [31:0] exp_res, input logic exp_cout,
                        input logic exp_zero, input logic exp_ovf);
        drive(va, vb, vbinv, vop, vcin);
        @(posedge clk);
        #1;
        chk({tag, "_res"}, Result, exp_res);
        chk({tag, "_cout"}, 32'(CarryOut), 32'(exp_cout));
`ifdef ALU_FLAGS_EN
        chk({tag, "_zero"}, 32'(Zero), 32'(exp_zero));
        chk({tag, "_ovf"}, 32'(Overflow), 32'(exp_ovf));
`else
        if (exp_zero === 1'bx && exp_ovf === 1'bx) $display("[TB] unexpected flag args");
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        drive($urandom, $urandom, 1'b1, 2'b10, 1'b1);
        @(posedge clk);
        drive($urandom, $urandom, 1'b0, 2'b01, 1'b1);
        @(posedge clk);
        #1;
        chk("reset_res", Result, 32'h0000_0000);
        chk("reset_cout", 32'(CarryOut), 32'h0);
`ifdef ALU_FLAGS_EN
        chk("reset_zero", 32'(Zero), 32'h1);
        chk("reset_ovf", 32'(Overflow), 32'h0);
`endif

        // Release reset together with the first vector; output must not change before the edge.
        rst_n = 1'b1;
        drive(32'ha5a5_a505, 32'h5a5a_5a5a, 1'b0, 2'b01, 1'b0);
        #1;
        chk("hold_before_edge", Result, 32'h0000_0000);

        // Back-to-back: a new operation every cycle, each checked one edge later.
        step("or",        32'ha5a5_a505, 32'h5a5a_5a5a, 1'b0, 2'b01, 1'b0, 32'hffff_ff5f, 1'b0, 1'b0, 1'b0);
        step("and",       32'ha5a5_a505, 32'h5a5a_5a5a, 1'b0, 2'b00, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        step("add",       32'ha5a5_a505, 32'h5a5a_5a5a, 1'b0, 2'b10, 1'b0, 32'hffff_ff5f, 1'b0, 1'b0, 1'b0);
        step("sub_cin0",  32'ha5a5_a505, 32'h5a5a_5a5a, 1'b1, 2'b10, 1'b0, 32'h4b4b_4aaa, 1'b1, 1'b0, 1'b1);
        step("sub_cin1",  32'ha5a5_a505, 32'h5a5a_5a5a, 1'b1, 2'b10, 1'b1, 32'h4b4b_4aab, 1'b1, 1'b0, 1'b1);
        step("add_ovf",   32'h7fff_ffff, 32'h0000_0001, 1'b0, 2'b10, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        step("slt_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 2'b11, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
        step("slt_ge",    32'h0000_0005, 32'h0000_0003, 1'b1, 2'b11, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        step("slt_lt",    32'h0000_0003, 32'h0000_0005, 1'b1, 2'b11, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        step("and_cout",  32'hffff_ffff, 32'h0000_0001, 1'b0, 2'b00, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        step("and_noovf", 32'h7fff_ffff, 32'h0000_0001, 1'b0, 2'b00, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        step("or_inv",    32'h0000_0000, 32'hffff_00ff, 1'b1, 2'b01, 1'b0, 32'h0000_ff00, 1'b0, 1'b0, 1'b0);

        // Mid-stream reset wins over a live operation.
        rst_n = 1'b0;
        drive(32'hffff_ffff, 32'hffff_ffff, 1'b0, 2'b10, 1'b1);
        @(posedge clk);
        #1;
        chk("midreset_res", Result, 32'h0000_0000);
        chk("midreset_cout", 32'(CarryOut), 32'h0);
        rst_n = 1'b1;
        step("after_reset", 32'hffff_ffff, 32'hffff_ffff, 1'b0, 2'b10, 1'b1, 32'hffff_ffff, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
